// File: rtl/fp48_align_denorm.sv
// fp48_align_denorm
//   Iterative right-shift alignment unit for the 48-bit float format
//   {sign, exp[10:0], frac[35:0]}, bias 1023. It unpacks an operand into a
//   40-bit significand {hidden, frac, G, R, S}. It then shifts the significand
//   right, at most STEP bits per cycle, until the exponent reaches texp_i.
//   Bits shifted out are ORed into the sticky bit S.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   ce              clock enable; low freezes every register
//   valid_i/ready_o operand handshake (ready_o high only when idle)
//   a_i, texp_i     packed operand, target exponent (sampled at acceptance)
//   valid_o/ready_i result handshake
//   sign_o, exp_o   operand sign, aligned exponent
//   man_o           {hidden, frac[35:0], G, R, S}
//   inexact_o       sticky bit of the result
//   special_o       operand exponent was all ones (Inf/NaN)
//   align_err_o     texp_i below effective exponent; no shift applied
module fp48_align_denorm #(
  parameter int unsigned STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [47:0] a_i,
  input  logic [10:0] texp_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sign_o,
  output logic [10:0] exp_o,
  output logic [39:0] man_o,
  output logic        inexact_o,
  output logic        special_o,
  output logic        align_err_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [5:0] STEP_W = 6'(STEP);

  state_t      state, state_nx;
  logic [5:0]  rem;
  logic [39:0] man;

  // Operand unpack and shift distance
  logic [10:0] op_exp, eexp;
  logic        exp_zero, is_special, neg;
  logic [11:0] diff;
  logic [5:0]  d_in;
  logic        accept;

  always_comb begin
    op_exp     = a_i[46:36];
    exp_zero   = (op_exp == '0);
    is_special = (op_exp == '1);
    eexp       = exp_zero ? 11'd1 : op_exp;
    diff       = {1'b0, texp_i} - {1'b0, eexp};
    neg        = diff[11];
    if (is_special || neg) d_in = '0;
    else if (diff > 12'd40) d_in = 6'd40;
    else                    d_in = diff[5:0];
    accept     = valid_i && (state == IDLE) && ce;
  end

  // One shift step: at most STEP bits. The shifted-out bits, including the
  // old sticky bit, fold into bit 0.
  logic [5:0]  s, rem_nx;
  logic [39:0] shifted, lost_mask, man_sh;

  always_comb begin
    s         = (rem < STEP_W) ? rem : STEP_W;
    shifted   = man >> s;
    lost_mask = ~({40{1'b1}} << s);
    man_sh    = {shifted[39:1], shifted[0] | (|(man & lost_mask))};
    rem_nx    = rem - s;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (d_in == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_nx == '0) state_nx = DONE;
      DONE:    if (ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  state <= IDLE;
    else if (ce) state <= state_nx;
  end

  logic        sign_r, special_r, err_r;
  logic [10:0] exp_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      special_r <= 1'b0;
      err_r     <= 1'b0;
      exp_r     <= '0;
      man       <= '0;
      rem       <= '0;
    end else if (ce) begin
      if (accept) begin
        sign_r    <= a_i[47];
        special_r <= is_special;
        err_r     <= !is_special && neg;
        man       <= {!exp_zero && !is_special, a_i[35:0], 3'b000};
        rem       <= d_in;
        if (is_special)         exp_r <= '1;
        else if (d_in != '0)    exp_r <= texp_i;
        else                    exp_r <= eexp;
      end else if (state == SHIFT) begin
        man <= man_sh;
        rem <= rem_nx;
      end
    end
  end

  always_comb begin
    ready_o     = (state == IDLE);
    valid_o     = (state == DONE);
    sign_o      = sign_r;
    exp_o       = exp_r;
    man_o       = man;
    inexact_o   = man[0];
    special_o   = special_r;
    align_err_o = err_r;
  end

endmodule

// File: doc/fp48_align_denorm.md
# fp48_align_denorm

Sequential right-shift alignment unit for the 48-bit format (1 sign, 11-bit exponent, bias 1023, 36-bit fraction). It is the opposite direction of the normalizer: it unpacks a packed operand into a 40-bit working significand and shifts it right until its exponent equals a supplied target exponent, accumulating guard, round and sticky bits. It feeds the adder and fused-multiply-add pre-alignment path. It uses an iterative shifter with a valid/ready handshake on both sides.

## Interface
- STEP, 8: maximum right-shift distance per SHIFT cycle (1..40).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- valid_i  in  1  input operand valid.
- ready_o  out  1  unit can accept an operand.
- a_i  in  48  packed operand, {sign, exp[10:0], frac[35:0]}.
- texp_i  in  11  target (larger) exponent.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- sign_o  out  1  operand sign.
- exp_o  out  11  result exponent.
- man_o  out  40  {hidden, frac[35:0], G, R, S}.
- inexact_o  out  1  nonzero bits were shifted into S.
- special_o  out  1  operand exponent was all ones (Inf/NaN).
- align_err_o  out  1  texp_i < effective operand exponent; no shift applied.

## Operation
- Unpack at acceptance, when `valid_i && ready_o && ce`:
  - exp==0: hidden=0, effective exponent eexp=1 (denormal or zero).
  - Otherwise: hidden=1, eexp=exp.
  - man = {hidden, frac, 3'b000}.
- Shift distance, computed with a 12-bit subtract: d = texp_i − eexp.
  - If negative, d=0 and align_err is set.
  - Clamp d to 40; clamping cannot lose information because sticky absorbs all bits.
- Special operand (exp==0x7FF): d forced to 0; man = {0, frac, 000}; exp_o=0x7FF; special_o=1.
- States:
  - IDLE (ready_o=1).
  - SHIFT.
  - DONE (valid_o=1).
- Transitions:
  - IDLE → SHIFT on acceptance with d>0.
  - IDLE → DONE on acceptance with d==0.
  - SHIFT: s = min(rem, STEP); man <= man >> s; man[0] <= (man>>s)[0] | OR(man[s−1:0]); rem <= rem − s. Go to DONE when rem−s==0.
  - DONE → IDLE on ready_i.
- exp_o is texp_i if d>0 was applied; otherwise eexp (or 0x7FF for specials).
- inexact_o = man_o[0] at DONE.
- ready_o is high only in IDLE. valid_i outside IDLE is ignored; the upstream must hold it.
- Result outputs are registered; they are stable and unchanged for the whole of DONE.

## Timing
- Reset (rst_n low at an edge, ce ignored for reset):
  - State goes to IDLE.
  - ready_o=1, valid_o=0.
  - sign_o, exp_o, man_o, inexact_o, special_o, align_err_o all 0.
- Reset mid-SHIFT or mid-DONE discards the transaction; there is no partial result.
- Latency from the acceptance edge to valid_o high:
  - 1 cycle if d==0.
  - Otherwise 1 + ceil(min(d,40)/STEP) cycles; with STEP=8, maximum 6.
- Throughput: one operand per latency+1 cycles when ready_i is held high. IDLE always takes one cycle between results.
- ce low: state, counters and outputs freeze. The handshake does not complete, regardless of valid_i and ready_i.
- valid_o and ready_i high in the same cycle completes output. The next acceptance can occur no earlier than the following edge.

## Test plan
- 1.0 (a_i=0x3FF000000000), texp=0x402: man_o=0x1000000000, exp_o=0x402, inexact_o=0, valid_o 2 cycles after acceptance.
- a_i=0x3FF000000001, texp=0x404: man_o=0x0400000001, inexact_o=1, latency 2.
- 1.0, texp=0x463 (d=100, clamped to 40): man_o=0x0000000001, inexact_o=1, latency 6. Repeat with STEP=1: latency 41.
- NaN a_i=0x7FF800000000, texp=0x400: special_o=1, exp_o=0x7FF, man_o={0, frac, 000}, latency 1. Separately, texp=0x3FE with 1.0: align_err_o=1, man_o=0x8000000000.
- Backpressure: hold ready_i low 10 cycles in DONE while valid_i pulses with new data. Outputs stay constant, ready_o=0, the second operand is not accepted until after ready_i.
- Reset and ce:
  - Assert rst_n low during the 3rd SHIFT cycle: next cycle, valid_o=0, ready_o=1, all outputs 0.
  - Drop ce for 5 cycles mid-SHIFT: latency is extended by exactly 5 and the result is unchanged.
